route_reserve_arbiter: RTL
==========================

ROUTE_RESERVE_ARBITER -- requirements
Module: route_reserve_arbiter

Interface
REQ-001 SHALL have parameter PORTS, default 5, meaning number of router ports; each port is both an input and an output.
REQ-002 SHALL have parameter REQUEST_WIDTH, default 3, meaning width of one encoded output-port index, at least clog2(PORTS).
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, meaning synchronous active-high reset.
REQ-005 SHALL have port routeReserveRequestValid, input, PORTS, meaning bit i high while input i requests an output.
REQ-006 SHALL have port routeReserveRequest, input, PORTS*REQUEST_WIDTH, meaning slice i is the requested output index of input i.
REQ-007 SHALL have port routeRelease, input, PORTS, meaning a one-cycle pulse on bit i when input i's tail flit has passed, freeing the output it holds.
REQ-008 SHALL have port routeReserveStatus, output, PORTS, meaning a one-cycle grant pulse to input i.
REQ-009 SHALL have port outputBusy, output, PORTS, meaning bit o high while output o is reserved.
REQ-010 SHALL have port outputSelect, output, PORTS*REQUEST_WIDTH, meaning slice o is the input index owning output o, for the crossbar mux.

Function
REQ-011 SHALL hold per output o a 2-state FSM (FREE, RESERVED), an owner register and a round-robin pointer; it SHALL hold per input i a holds-grant flag.
REQ-012 SHALL treat input i as eligible for output o when all of: valid[i]=1, request slice i equals o, holds[i]=0, and routeReserveStatus[i]=0.
REQ-013 SHALL, for each FREE output with at least one eligible input, choose the first eligible input at or after pointer[o], searching upward with wrap-around modulo PORTS.
REQ-014 SHALL, on the edge following selection of input i for output o, set the state to RESERVED, owner[o]=i, holds[i]=1, pointer[o]=(i+1) mod PORTS, and drive routeReserveStatus[i]=1 for exactly that next cycle (latency: request visible -> grant pulse one cycle later).
REQ-015 SHALL grant at most one output per input per cycle; this is guaranteed because each input requests exactly one output.
REQ-016 SHALL grant distinct outputs to distinct inputs concurrently in the same cycle.
REQ-017 SHALL, on routeRelease[i] with holds[i]=1, return the output owned by i to FREE and clear holds[i] at the next edge; outputSelect[o] SHALL keep its last value.
REQ-018 SHALL NOT regrant an output in the same cycle it is released; the earliest regrant is the following cycle.
REQ-019 SHALL ignore routeRelease[i] when holds[i]=0.
REQ-020 SHALL ignore requests whose index is >= PORTS; such requests are never granted.
REQ-021 SHALL leave requests that are not granted pending without side effects; pointers SHALL change only on a grant.
REQ-022 SHALL drive outputBusy[o]=1 exactly when the output o FSM is RESERVED; all outputs SHALL be registered.

Reset
REQ-023 SHALL, with rst high at an edge, force every output FSM to FREE, every owner to 0, every pointer to 0, every holds flag to 0, routeReserveStatus=0, outputBusy=0 and outputSelect=0.
REQ-024 SHALL drop all reservations and any grant that is in flight when reset is asserted mid-operation, and SHALL not issue any grant in the cycle after reset.

Configuration
REQ-025 SHALL, with macro ROUTE_ARB_ROUND_ROBIN_EN defined, arbitrate as described in REQ-013 and REQ-014.
REQ-026 SHALL, without ROUTE_ARB_ROUND_ROBIN_EN, use fixed priority: the lowest eligible input index wins; pointers are not implemented and REQ-014 pointer updates do not apply.

Verification
REQ-027 SHALL cover single request: PORTS=5, input 2 requests output 4 -> routeReserveStatus[2] pulses one cycle later, outputBusy[4]=1, outputSelect[4]=2.
REQ-028 SHALL cover round-robin contention: inputs 0, 1 and 3 request output 2 and each releases after its grant -> grants occur in order 0, 1, 3, 0 (with the macro defined); in order 0, 0, 0 (without it).
REQ-029 SHALL cover release and regrant: input 1 owns output 0 and input 3 is waiting; routeRelease[1] pulses at cycle t -> output 0 is FREE at t+1, and routeReserveStatus[3] pulses at t+2, not earlier.
REQ-030 SHALL cover parallel grants: inputs 0->1, 1->2 and 2->0 are requested in the same cycle -> all three status bits pulse in the same cycle.
REQ-031 SHALL cover illegal and spurious events: a request index of 6 and a routeRelease on an idle input -> no grant and no change of state.
REQ-032 SHALL cover reset mid-operation: rst is asserted while outputs 1 and 3 are reserved -> all outputs are FREE and all outputs are 0 the next cycle, and no status pulse occurs.

Source files
------------

// File: rtl/route_reserve_arbiter_if.sv
// Request, release, grant and crossbar-select bundle between the input ports and the route arbiter.
interface route_reserve_arbiter_if #(
  parameter int PORTS         = 5,
  parameter int REQUEST_WIDTH = 3
);
  logic [PORTS-1:0]               routeReserveRequestValid;
  logic [PORTS*REQUEST_WIDTH-1:0] routeReserveRequest;
  logic [PORTS-1:0]               routeRelease;
  logic [PORTS-1:0]               routeReserveStatus;
  logic [PORTS-1:0]               outputBusy;
  logic [PORTS*REQUEST_WIDTH-1:0] outputSelect;

  modport master (
    output routeReserveRequestValid, routeReserveRequest, routeRelease,
    input  routeReserveStatus, outputBusy, outputSelect
  );

  modport slave (
    input  routeReserveRequestValid, routeReserveRequest, routeRelease,
    output routeReserveStatus, outputBusy, outputSelect
  );
endinterface

// File: rtl/route_reserve_arbiter.sv
// Output reservation arbiter: grants free outputs to requesting inputs, holds ownership until release.
// Define ROUTE_ARB_ROUND_ROBIN_EN for per-output round-robin; default build is fixed lowest-index priority.
module route_reserve_arbiter #(
  parameter int PORTS         = 5,
  parameter int REQUEST_WIDTH = 3
) (
  input logic clk,
  input logic rst,
  route_reserve_arbiter_if.slave bus
);
  typedef enum logic {FREE = 1'b0, RESERVED = 1'b1} out_state_e;

  out_state_e               state_q [PORTS];
  logic [REQUEST_WIDTH-1:0] owner_q [PORTS];
  logic [PORTS-1:0]         holds_q, holds_d;
  logic [PORTS-1:0]         status_q, status_d;
`ifdef ROUTE_ARB_ROUND_ROBIN_EN
  logic [REQUEST_WIDTH-1:0] ptr_q [PORTS];
`endif

  logic [PORTS-1:0]         elig [PORTS];
  logic [PORTS-1:0]         gnt_vld;
  logic [PORTS-1:0]         rel_out;
  logic [REQUEST_WIDTH-1:0] gnt_idx [PORTS];

  // elig[o][i]: input i may be granted output o this cycle
  always_comb begin
    for (int o = 0; o < PORTS; o++) begin
      for (int i = 0; i < PORTS; i++) begin
        elig[o][i] = bus.routeReserveRequestValid[i]
                   && (bus.routeReserveRequest[i*REQUEST_WIDTH +: REQUEST_WIDTH] == REQUEST_WIDTH'(o))
                   && !holds_q[i] && !status_q[i];
      end
    end
  end

  always_comb begin
    int idx;
    idx = 0;
    for (int o = 0; o < PORTS; o++) begin
      gnt_vld[o] = 1'b0;
      gnt_idx[o] = '0;
      for (int k = 0; k < PORTS; k++) begin
`ifdef ROUTE_ARB_ROUND_ROBIN_EN
        idx = int'(ptr_q[o]) + k;
        if (idx >= PORTS) idx = idx - PORTS;
`else
        idx = k;
`endif
        for (int i = 0; i < PORTS; i++) begin
          if (i == idx && state_q[o] == FREE && !gnt_vld[o] && elig[o][i]) begin
            gnt_vld[o] = 1'b1;
            gnt_idx[o] = REQUEST_WIDTH'(i);
          end
        end
      end
    end
  end

  // A release frees the owned output at the next edge; selection only sees FREE outputs,
  // so the earliest regrant lands one cycle after that.
  always_comb begin
    for (int i = 0; i < PORTS; i++) begin
      status_d[i] = 1'b0;
      for (int o = 0; o < PORTS; o++) begin
        if (gnt_vld[o] && gnt_idx[o] == REQUEST_WIDTH'(i)) status_d[i] = 1'b1;
      end
    end
    for (int o = 0; o < PORTS; o++) begin
      rel_out[o] = 1'b0;
      for (int i = 0; i < PORTS; i++) begin
        if (state_q[o] == RESERVED && owner_q[o] == REQUEST_WIDTH'(i)
            && bus.routeRelease[i] && holds_q[i]) rel_out[o] = 1'b1;
      end
    end
    holds_d = (holds_q & ~bus.routeRelease) | status_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      holds_q  <= '0;
      status_q <= '0;
      for (int o = 0; o < PORTS; o++) begin
        state_q[o] <= FREE;
        owner_q[o] <= '0;
`ifdef ROUTE_ARB_ROUND_ROBIN_EN
        ptr_q[o]   <= '0;
`endif
      end
    end else begin
      holds_q  <= holds_d;
      status_q <= status_d;
      for (int o = 0; o < PORTS; o++) begin
        case (state_q[o])
          FREE: begin
            if (gnt_vld[o]) begin
              state_q[o] <= RESERVED;
              owner_q[o] <= gnt_idx[o];
`ifdef ROUTE_ARB_ROUND_ROBIN_EN
              ptr_q[o]   <= (gnt_idx[o] == REQUEST_WIDTH'(PORTS-1)) ? '0
                                                                    : gnt_idx[o] + REQUEST_WIDTH'(1);
`endif
            end
          end
          RESERVED: begin
            if (rel_out[o]) state_q[o] <= FREE;
          end
          default: state_q[o] <= FREE;
        endcase
      end
    end
  end

  always_comb begin
    bus.routeReserveStatus = status_q;
    for (int o = 0; o < PORTS; o++) begin
      bus.outputBusy[o] = (state_q[o] == RESERVED);
      bus.outputSelect[o*REQUEST_WIDTH +: REQUEST_WIDTH] = owner_q[o];
    end
  end
endmodule
